// File: rtl/conv_pool_engine.sv
// conv_pool_engine: streaming KxK convolution / 2x2 max-pool engine that
// runs on a word-addressed image held behind a Wishbone master port.
//   CLK, rst            : clock, asynchronous active-high reset
//   start, mode         : begin a job; mode 0 = conv, 1 = 2x2 maxpool
//   kernel_base/src_base/dst_base : word base addresses, latched on start
//   busy, done          : engine active; one-cycle completion pulse
//   out_count           : results written by the current/last job
//   cyc_i..data_i       : master request outputs (one transaction in flight)
//   data_o, stall_o, sdram_ack : slave read data, stall and acknowledge
module conv_pool_engine #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int FRAC   = 8,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] kernel_base,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [15:0]       out_count,
  output logic              cyc_i,
  output logic              stb_i,
  output logic              we_i,
  output logic [3:0]        sel_i,
  output logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       data_i,
  input  logic [31:0]       data_o,
  input  logic              stall_o,
  input  logic              sdram_ack
);

  if (K > IMG_W || K > IMG_H) begin : g_bad_k
    $error("conv_pool_engine: K must not exceed IMG_W or IMG_H");
  end

  localparam int KK = K * K;
  localparam int AW = 2 * DATA_W + $clog2(KK);
  localparam int IW = (KK > 1) ? $clog2(KK) : 1;
  localparam logic signed [AW-1:0] SMAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_KERNEL, FETCH, WRITE, DONE} state_t;

  state_t                   state;
  logic                     mode_q;
  logic [ADDR_W-1:0]        kb, sb, db;
  logic [15:0]              n, i, j, r, c;
  logic signed [AW-1:0]     acc;
  logic [KK-1:0][DATA_W-1:0] w;

  // geometry of the current job
  logic [15:0]       win, ow, oh;
  logic [ADDR_W-1:0] stride;
  assign win    = mode_q ? 16'd2 : 16'(K);
  assign ow     = mode_q ? 16'(IMG_W / 2) : 16'(IMG_W - K + 1);
  assign oh     = mode_q ? 16'(IMG_H / 2) : 16'(IMG_H - K + 1);
  assign stride = mode_q ? ADDR_W'(2) : ADDR_W'(1);

  logic [ADDR_W-1:0] req_addr;
  always_comb begin
    req_addr = kb + ADDR_W'(n);
    if (state == FETCH)
      req_addr = sb + (ADDR_W'(r) * stride + ADDR_W'(i)) * ADDR_W'(IMG_W)
                    + ADDR_W'(c) * stride + ADDR_W'(j);
    else if (state == WRITE)
      req_addr = db + ADDR_W'(r) * ADDR_W'(ow) + ADDR_W'(c);
  end

  // datapath: only the low DATA_W bits of read data are meaningful
  logic signed [DATA_W-1:0] pix;
  logic [IW-1:0]            widx;
  logic signed [AW-1:0]     prod, pix_x, shifted;
  logic signed [DATA_W-1:0] res;
  logic                     unused_hi;
  assign pix       = data_o[DATA_W-1:0];
  assign unused_hi = &{1'b0, data_o[31:DATA_W]};
  assign widx      = IW'(i * 16'(K) + j);
  assign prod      = AW'($signed(w[widx])) * AW'(pix);
  assign pix_x     = AW'(pix);
  assign shifted   = acc >>> FRAC;

  always_comb begin
    res = '0;
    if (mode_q)              res = acc[DATA_W-1:0];
    else if (shifted > SMAX) res = SMAX[DATA_W-1:0];
    else if (shifted < SMIN) res = SMIN[DATA_W-1:0];
    else                     res = shifted[DATA_W-1:0];
  end

  logic win_last, ack_ok, in_bus;
  assign win_last = (i == win - 16'd1) && (j == win - 16'd1);
  // ack only counts against an accepted (or same-cycle accepted) request
  assign ack_ok   = cyc_i && sdram_ack && (!stb_i || !stall_o);
  assign in_bus   = (state == LOAD_KERNEL) || (state == FETCH) || (state == WRITE);

  assign busy  = (state != IDLE);
  assign sel_i = cyc_i ? 4'b0011 : 4'b0000;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;   mode_q <= 1'b0;
      kb <= '0; sb <= '0; db <= '0;
      n <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
      acc <= '0; w <= '0;
      done <= 1'b0; out_count <= '0;
      cyc_i <= 1'b0; stb_i <= 1'b0; we_i <= 1'b0;
      addr_i <= '0; data_i <= '0;
    end else begin
      done <= 1'b0;

      // shared bus sequencer: issue when idle, drop stb on accept, drop cyc on ack
      if (in_bus) begin
        if (!cyc_i) begin
          cyc_i  <= 1'b1;
          stb_i  <= 1'b1;
          we_i   <= (state == WRITE);
          addr_i <= req_addr;
          data_i <= (state == WRITE) ? 32'(res) : 32'd0;
        end else begin
          if (stb_i && !stall_o) stb_i <= 1'b0;
          if (ack_ok) begin
            cyc_i <= 1'b0; stb_i <= 1'b0; we_i <= 1'b0;
          end
        end
      end

      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          kb <= kernel_base; sb <= src_base; db <= dst_base;
          out_count <= '0; acc <= '0;
          n <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
          state <= mode ? FETCH : LOAD_KERNEL;
        end
        LOAD_KERNEL: if (ack_ok) begin
          w[IW'(n)] <= data_o[DATA_W-1:0];
          if (n == 16'(KK - 1)) begin
            n <= '0; state <= FETCH;
          end else n <= n + 16'd1;
        end
        FETCH: if (ack_ok) begin
          if (!mode_q)                              acc <= acc + prod;
          else if ((i == 0 && j == 0) || pix_x > acc) acc <= pix_x;
          if (j == win - 16'd1) begin
            j <= '0;
            if (i == win - 16'd1) i <= '0;
            else                  i <= i + 16'd1;
          end else j <= j + 16'd1;
          if (win_last) state <= WRITE;
        end
        WRITE: if (ack_ok) begin
          out_count <= out_count + 16'd1;
          acc <= '0;
          if (c == ow - 16'd1) begin
            c <= '0;
            if (r == oh - 16'd1) begin
              r <= '0; state <= DONE; done <= 1'b1;
            end else r <= r + 16'd1;
          end else c <= c + 16'd1;
          if (!(c == ow - 16'd1 && r == oh - 16'd1)) state <= FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench for conv_pool_engine: a Wishbone slave model serves kernel
// and image words, records every write, and a scoreboard of expected
// (address, data) pairs is checked after each job.
module tb_conv_pool_engine;
  localparam logic [31:0] KB = 32'h100, SB = 32'h200, DB = 32'h400;

  logic        CLK = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [31:0] kernel_base = '0, src_base = '0, dst_base = '0;
  logic        busy, done, cyc_i, stb_i, we_i;
  logic [15:0] out_count;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        stall_o = 1'b0, ack_r, stray_ack = 1'b0, sdram_ack;
  assign sdram_ack = ack_r | stray_ack;

  conv_pool_engine dut (
    .CLK(CLK), .rst(rst), .start(start), .mode(mode),
    .kernel_base(kernel_base), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .out_count(out_count),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .stall_o(stall_o), .sdram_ack(sdram_ack)
  );

  always #5 CLK = ~CLK;

  // memory contents
  int pat;
  int wts [9];

  function automatic int pix_val(int r, int c);
    case (pat)
      0:       return r * 10 + c;
      1:       return 32767;
      2:       return -32768;
      default: return -5;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(logic [31:0] a);
    int off;
    if (a >= KB && a < KB + 9) begin
      off = int'(a - KB);
      return {16'hDEAD, 16'(wts[off])};
    end
    if (a >= SB && a < SB + 100) begin
      off = int'(a - SB);
      return {16'hBEEF, 16'(pix_val(off / 10, off % 10))};
    end
    return 32'hBAD0BAD0;
  endfunction

  // slave: ack one cycle after acceptance
  logic [31:0] obs_addr[$], obs_data[$];
  int rd_cnt = 0, done_cnt = 0, sel_bad = 0;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      ack_r  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_r <= 1'b0;
      if (done) done_cnt <= done_cnt + 1;
      if ((cyc_i && sel_i != 4'b0011) || (!cyc_i && sel_i != 4'b0000)) sel_bad <= sel_bad + 1;
      if (cyc_i && stb_i && !stall_o) begin
        ack_r <= 1'b1;
        if (we_i) begin
          obs_addr.push_back(addr_i);
          obs_data.push_back(data_i);
          data_o <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1;
          data_o <= rd_model(addr_i);
        end
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [31:0] a; logic [31:0] d; } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] conv_ref(int r, int c);
    longint acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(pix_val(r + i, c + j)) * longint'(wts[i*3+j]);
    acc = acc >>> 8;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 32'(acc);
  endfunction

  task automatic begin_job(input logic m, output int base, output int d0);
    base = obs_addr.size();
    d0   = done_cnt;
    @(negedge CLK);
    mode = m; kernel_base = KB; src_base = SB; dst_base = DB; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int base, input int d0, input int n);
    exp_t e;
    int t = 0;
    while (busy && t < 20000) begin @(negedge CLK); t++; end
    chk({tag, "_finish"}, {31'd0, busy}, 32'd0);
    chk({tag, "_nwrites"}, 32'(obs_addr.size() - base), 32'(n));
    chk({tag, "_out_count"}, {16'd0, out_count}, 32'(n));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      if (base + k < obs_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, k), obs_addr[base+k], e.a);
        chk($sformatf("%s_data%0d", tag, k), obs_data[base+k], e.d);
      end
    end
  endtask

  task automatic push_centre();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        push_exp(DB + 32'(r*8 + c), 32'((r+1)*10 + (c+1)));
  endtask

  task automatic set_centre();
    for (int k = 0; k < 9; k++) wts[k] = 0;
    wts[4] = 256;
  endtask

  initial begin
    int base, d0, r0, t;
    logic [31:0] a0;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_cyc", {31'd0, cyc_i}, 32'd0);
    chk("rst_stb", {31'd0, stb_i}, 32'd0);
    chk("rst_we", {31'd0, we_i}, 32'd0);
    chk("rst_sel", {28'd0, sel_i}, 32'd0);
    chk("rst_addr", addr_i, 32'd0);
    chk("rst_data", data_i, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    rst = 1'b0;

    // stray ack while idle does nothing
    @(negedge CLK); stray_ack = 1'b1;
    @(negedge CLK); stray_ack = 1'b0;
    @(negedge CLK);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_cyc", {31'd0, cyc_i}, 32'd0);

    // conv, centre tap only
    pat = 0; set_centre();
    push_centre();
    begin_job(1'b0, base, d0);
    finish_job("conv_centre", base, d0, 64);

    // same job with the first read stalled for 5 cycles
    push_centre();
    r0 = rd_cnt;
    stall_o = 1'b1;
    begin_job(1'b0, base, d0);
    t = 0;
    while (!stb_i && t < 100) begin @(negedge CLK); t++; end
    chk("stall_first_addr", addr_i, KB);
    a0 = addr_i;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("stall_stb%0d", k), {31'd0, stb_i}, 32'd1);
      chk($sformatf("stall_addr%0d", k), addr_i, a0);
    end
    stall_o = 1'b0;
    finish_job("conv_stall", base, d0, 64);
    chk("stall_reads", 32'(rd_cnt - r0), 32'(9 + 64*9));

    // saturation high and low
    pat = 1;
    for (int k = 0; k < 9; k++) wts[k] = 256;
    for (int k = 0; k < 64; k++) push_exp(DB + 32'(k), 32'h0000_7FFF);
    begin_job(1'b0, base, d0);
    finish_job("conv_sat_hi", base, d0, 64);
    pat = 2;
    for (int k = 0; k < 64; k++) push_exp(DB + 32'(k), 32'hFFFF_8000);
    begin_job(1'b0, base, d0);
    finish_job("conv_sat_lo", base, d0, 64);

    // asymmetric weights against the reference model
    pat = 0;
    for (int k = 0; k < 9; k++) wts[k] = 32*k - 100;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) push_exp(DB + 32'(r*8 + c), conv_ref(r, c));
    begin_job(1'b0, base, d0);
    finish_job("conv_mixed", base, d0, 64);

    // 2x2 maxpool
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) push_exp(DB + 32'(r*5 + c), 32'((2*r+1)*10 + 2*c + 1));
    begin_job(1'b1, base, d0);
    finish_job("pool_ramp", base, d0, 25);
    pat = 3;
    for (int k = 0; k < 25; k++) push_exp(DB + 32'(k), 32'hFFFF_FFFB);
    begin_job(1'b1, base, d0);
    finish_job("pool_neg", base, d0, 25);

    // reset during the 10th write, then a clean rerun
    pat = 0; set_centre();
    begin_job(1'b0, base, d0);
    t = 0;
    while (obs_addr.size() - base < 9 && t < 5000) begin @(negedge CLK); t++; end
    t = 0;
    while (!(cyc_i && we_i && stb_i) && t < 200) begin @(negedge CLK); t++; end
    chk("abort_reached_write", {31'd0, cyc_i & we_i}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_cyc", {31'd0, cyc_i}, 32'd0);
    chk("abort_stb", {31'd0, stb_i}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK); rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_out_count", {16'd0, out_count}, 32'd0);
    push_centre();
    begin_job(1'b0, base, d0);
    finish_job("after_abort", base, d0, 64);

    // start re-asserted while busy is ignored
    push_centre();
    begin_job(1'b0, base, d0);
    repeat (20) @(negedge CLK);
    mode = 1'b1; dst_base = 32'h800; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    finish_job("restart_busy", base, d0, 64);

    chk("sel_protocol", 32'(sel_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
